// File: rtl/datapath_ctrl.sv
// datapath_ctrl: microcoded-style control unit for a register-file + ALU
// datapath. Fetches 16-bit instructions from a synchronous ROM, decodes them
// and sequences the datapath control strobes. Conditional branches use the
// datapath's z/n flags.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   start_i               pulse in IDLE: begin execution at pc=0
//   instr_i               ROM data, valid the cycle after imem_re_o
//   pc_o, imem_re_o       ROM address and read strobe
//   din_o                 immediate to datapath
//   waddr_o, ra_o, rb_o   register write / read addresses
//   op_o                  ALU operation
//   ie_o                  datapath input select (1 = din_o)
//   write_o               register write enable
//   reada_o, readb_o      register read-port enables
//   en_o                  ALU / flag register enable
//   oe_o                  datapath output enable
//   o_flag_i, z_flag_i, n_flag_i   datapath flags
//   busy_o                high in every state except IDLE and HALT
//   halted_o              high in HALT
//
// Instruction format: [15:12] opc, [11:9] rd, [8:6] rs_a, [5:3] rs_b,
// [7:0] imm / branch target.
// Cycle counts: ALU 4, LDI 3, OUT 3, branch/NOP 2.
module datapath_ctrl #(
  parameter int M  = 3,
  parameter int N  = 8,
  parameter int PW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start_i,
  input  logic [15:0]   instr_i,
  input  logic          o_flag_i,
  input  logic          z_flag_i,
  input  logic          n_flag_i,
  output logic [PW-1:0] pc_o,
  output logic          imem_re_o,
  output logic [N-1:0]  din_o,
  output logic [M-1:0]  waddr_o,
  output logic [M-1:0]  ra_o,
  output logic [M-1:0]  rb_o,
  output logic [2:0]    op_o,
  output logic          ie_o,
  output logic          write_o,
  output logic          reada_o,
  output logic          readb_o,
  output logic          en_o,
  output logic          oe_o,
  output logic          busy_o,
  output logic          halted_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_WB,
    S_HALT
  } state_e;

  localparam logic [3:0] OPC_LDI = 4'b1000;
  localparam logic [3:0] OPC_OUT = 4'b1001;
  localparam logic [3:0] OPC_BRZ = 4'b1010;
  localparam logic [3:0] OPC_BRN = 4'b1011;
  localparam logic [3:0] OPC_BRA = 4'b1100;
  localparam logic [3:0] OPC_HLT = 4'b1111;

  state_e        state_q, state_d;
  logic [PW-1:0] pc_q, pc_d;
  logic [15:0]   ir_q, ir_d;

  // Fields of the latched instruction; these alone drive the outputs.
  logic [3:0]   ir_opc;
  logic [M-1:0] ir_rd, ir_rs_a, ir_rs_b;
  logic [N-1:0] ir_imm;

  assign ir_opc  = ir_q[15:12];
  assign ir_rd   = M'(ir_q[11:9]);
  assign ir_rs_a = M'(ir_q[8:6]);
  assign ir_rs_b = M'(ir_q[5:3]);
  assign ir_imm  = N'(ir_q[7:0]);

  // The overflow flag is not consumed by any branch in this instruction set.
  logic unused_o_flag;
  assign unused_o_flag = o_flag_i;

  // NOTE: IR is an ordinary register, not a memory array, so it takes the
  // async reset like the rest of the state; nothing decoded after reset may
  // see a stale instruction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register updating from the
      // same pre-edge values, independent of statement order.
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  // Next-state logic. instr_i and the flags are consulted only in DECODE and
  // only to steer state/pc/IR; they never reach an output directly.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // it unassigned (which would infer a latch).
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;

    unique case (state_q)
      S_IDLE: begin
        if (start_i) state_d = S_FETCH;
      end
      S_FETCH: begin
        pc_d    = pc_q + PW'(1);
        state_d = S_DECODE;
      end
      S_DECODE: begin
        ir_d = instr_i;
        if (!instr_i[15]) begin
          state_d = S_EXEC;
        end else begin
          unique case (instr_i[15:12])
            OPC_LDI: state_d = S_WB;
            OPC_OUT: state_d = S_EXEC;
            OPC_HLT: state_d = S_HALT;
            OPC_BRZ: begin
              if (z_flag_i) pc_d = instr_i[PW-1:0];
              state_d = S_FETCH;
            end
            OPC_BRN: begin
              if (n_flag_i) pc_d = instr_i[PW-1:0];
              state_d = S_FETCH;
            end
            OPC_BRA: begin
              pc_d    = instr_i[PW-1:0];
              state_d = S_FETCH;
            end
            default: state_d = S_FETCH;  // NOP encodings
          endcase
        end
      end
      // Only ALU ops and OUT reach EXEC; OUT has no write-back.
      S_EXEC:  state_d = ir_opc[3] ? S_FETCH : S_WB;
      S_WB:    state_d = S_FETCH;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  // Moore outputs from state and IR only.
  always_comb begin
    pc_o      = pc_q;
    imem_re_o = 1'b0;
    din_o     = '0;
    waddr_o   = '0;
    ra_o      = '0;
    rb_o      = '0;
    op_o      = '0;
    ie_o      = 1'b0;
    write_o   = 1'b0;
    reada_o   = 1'b0;
    readb_o   = 1'b0;
    en_o      = 1'b0;
    oe_o      = 1'b0;
    busy_o    = (state_q != S_IDLE) && (state_q != S_HALT);
    halted_o  = (state_q == S_HALT);

    unique case (state_q)
      S_FETCH: imem_re_o = 1'b1;
      S_EXEC: begin
        reada_o = 1'b1;
        ra_o    = ir_rs_a;
        if (!ir_opc[3]) begin
          readb_o = 1'b1;
          en_o    = 1'b1;
          rb_o    = ir_rs_b;
          op_o    = ir_opc[2:0];
        end else begin
          oe_o = 1'b1;
        end
      end
      S_WB: begin
        write_o = 1'b1;
        waddr_o = ir_rd;
        if (ir_opc == OPC_LDI) begin
          ie_o  = 1'b1;
          din_o = ir_imm;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_datapath_ctrl.sv
module tb_datapath_ctrl;

  localparam int M  = 3;
  localparam int N  = 8;
  localparam int PW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [15:0]   instr;
  logic          o_flag, z_flag, n_flag;
  logic [PW-1:0] pc;
  logic          imem_re;
  logic [N-1:0]  din;
  logic [M-1:0]  waddr, ra, rb;
  logic [2:0]    op;
  logic          ie, write, reada, readb, en, oe, busy, halted;

  datapath_ctrl #(.M(M), .N(N), .PW(PW)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start), .instr_i(instr),
    .o_flag_i(o_flag), .z_flag_i(z_flag), .n_flag_i(n_flag),
    .pc_o(pc), .imem_re_o(imem_re), .din_o(din), .waddr_o(waddr),
    .ra_o(ra), .rb_o(rb), .op_o(op), .ie_o(ie), .write_o(write),
    .reada_o(reada), .readb_o(readb), .en_o(en), .oe_o(oe),
    .busy_o(busy), .halted_o(halted)
  );

  always #5 clk = ~clk;

  // Synchronous instruction ROM: data appears the cycle after the read strobe.
  logic [15:0] rom [256];
  always @(posedge clk) if (imem_re) instr <= rom[pc];

  typedef struct packed {
    logic [7:0] pc;
    logic       imem_re;
    logic [7:0] din;
    logic [2:0] waddr;
    logic [2:0] ra;
    logic [2:0] rb;
    logic [2:0] op;
    logic       ie, write, reada, readb, en, oe, busy, halted;
  } out_t;

  typedef struct {
    logic [15:0] ins;
    bit          z, n;
    int          len;     // cycles from this FETCH to the next FETCH
    logic [7:0]  npc;     // pc presented at the next FETCH
    out_t        last;    // outputs in the final cycle of the instruction
  } vec_t;

  int   n_checks = 0;
  int   n_pass   = 0;
  out_t exp_q[$];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  function automatic out_t snap();
    out_t o;
    o = '{pc: pc, imem_re: imem_re, din: din, waddr: waddr, ra: ra, rb: rb,
          op: op, ie: ie, write: write, reada: reada, readb: readb, en: en,
          oe: oe, busy: busy, halted: halted};
    return o;
  endfunction

  function automatic out_t base(input logic [7:0] p);
    out_t o;
    o = '0;
    o.pc = p;
    o.busy = 1'b1;
    return o;
  endfunction

  // Busy cycle with datapath controls; ctl = {ie, write, reada, readb, en, oe}.
  function automatic out_t act(input logic [7:0] p, input logic [7:0] d,
                               input logic [2:0] wa, input logic [2:0] a,
                               input logic [2:0] b, input logic [2:0] o_,
                               input logic [5:0] ctl);
    out_t o;
    o = base(p);
    o.din = d; o.waddr = wa; o.ra = a; o.rb = b; o.op = o_;
    {o.ie, o.write, o.reada, o.readb, o.en, o.oe} = ctl;
    return o;
  endfunction

  // Instruction-level reference: expands one instruction into its expected
  // per-cycle output trace and the address of the following instruction.
  task automatic model_instr(input logic [7:0] p, input logic [15:0] ins,
                             input bit zf, input bit nf,
                             output logic [7:0] npc, output bit hlt);
    out_t       c;
    logic [7:0] p1;
    logic [3:0] opc;
    opc = ins[15:12];
    p1  = p + 8'd1;
    npc = p1;
    hlt = 1'b0;
    c = base(p); c.imem_re = 1'b1; exp_q.push_back(c);
    exp_q.push_back(base(p1));
    if (opc < 4'd8) begin
      exp_q.push_back(act(p1, 8'h0, 3'd0, ins[8:6], ins[5:3], opc[2:0], 6'b001110));
      exp_q.push_back(act(p1, 8'h0, ins[11:9], 3'd0, 3'd0, 3'd0, 6'b010000));
    end else begin
      case (opc)
        4'h8: exp_q.push_back(act(p1, ins[7:0], ins[11:9], 3'd0, 3'd0, 3'd0, 6'b110000));
        4'h9: exp_q.push_back(act(p1, 8'h0, 3'd0, ins[8:6], 3'd0, 3'd0, 6'b001001));
        4'hA: if (zf) npc = ins[7:0];
        4'hB: if (nf) npc = ins[7:0];
        4'hC: npc = ins[7:0];
        4'hF: begin
          hlt = 1'b1;
          c = '0; c.pc = p1; c.halted = 1'b1;
          exp_q.push_back(c);
        end
        default: ;
      endcase
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Runs n_instr instructions from pc=0; caller has set start=1 in IDLE.
  task automatic run_prog(input int n_instr, input string tag);
    logic [7:0] p, npc;
    bit         zf, nf, of, hlt;
    int         cyc;
    out_t       e;
    p = 8'd0;
    for (int i = 0; i < n_instr; i++) begin
      zf = 1'($urandom); nf = 1'($urandom); of = 1'($urandom);
      model_instr(p, rom[p], zf, nf, npc, hlt);
      cyc = 0;
      while (exp_q.size() > 0) begin
        @(negedge clk);
        start = 1'b0;
        e = exp_q.pop_front();
        check($sformatf("%s i%0d c%0d ins=%h", tag, i, cyc, rom[p]), 64'(snap()), 64'(e));
        if (cyc == 0) begin
          z_flag = zf; n_flag = nf; o_flag = of;
        end
        cyc++;
      end
      p = npc;
      if (hlt) break;
    end
  endtask

  vec_t vecs[12];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    out_t       last, hpat;
    int         cyc;
    bit         done;

    vecs[0]  = '{16'h8205, 0, 0, 3, 8'h01, act(8'h01, 8'h05, 3'd1, 3'd0, 3'd0, 3'd0, 6'b110000)};
    vecs[1]  = '{16'h0250, 0, 0, 4, 8'h01, act(8'h01, 8'h00, 3'd1, 3'd0, 3'd0, 3'd0, 6'b010000)};
    vecs[2]  = '{16'h5E7A, 1, 1, 4, 8'h01, act(8'h01, 8'h00, 3'd7, 3'd0, 3'd0, 3'd0, 6'b010000)};
    vecs[3]  = '{16'h9180, 0, 0, 3, 8'h01, act(8'h01, 8'h00, 3'd0, 3'd6, 3'd0, 3'd0, 6'b001001)};
    vecs[4]  = '{16'hA020, 1, 0, 2, 8'h20, base(8'h01)};
    vecs[5]  = '{16'hA020, 0, 1, 2, 8'h01, base(8'h01)};
    vecs[6]  = '{16'hB033, 0, 1, 2, 8'h33, base(8'h01)};
    vecs[7]  = '{16'hB033, 1, 0, 2, 8'h01, base(8'h01)};
    vecs[8]  = '{16'hC0FF, 0, 0, 2, 8'hFF, base(8'h01)};
    vecs[9]  = '{16'hD123, 1, 1, 2, 8'h01, base(8'h01)};
    vecs[10] = '{16'hE000, 0, 0, 2, 8'h01, base(8'h01)};
    vecs[11] = '{16'h8EFF, 0, 0, 3, 8'h01, act(8'h01, 8'hFF, 3'd7, 3'd0, 3'd0, 3'd0, 6'b110000)};

    rst_n = 1'b0; start = 1'b0; o_flag = 1'b0; z_flag = 1'b0; n_flag = 1'b0;
    for (int i = 0; i < 256; i++) rom[i] = 16'hD000;
    #1;
    check("reset outputs zero", 64'(snap()), 64'h0);
    do_reset();
    check("idle after reset", 64'(snap()), 64'h0);
    @(negedge clk);
    check("idle holds without start", 64'(snap()), 64'h0);

    // Single-instruction table: latency, final-cycle outputs, next pc.
    foreach (vecs[k]) begin
      do_reset();
      for (int i = 0; i < 256; i++) rom[i] = 16'hD000;
      rom[0] = vecs[k].ins;
      z_flag = vecs[k].z; n_flag = vecs[k].n;
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      last = snap();
      cyc = 0; done = 1'b0;
      while (!done && cyc < 10) begin
        @(negedge clk);
        cyc++;
        if (imem_re) done = 1'b1;
        else last = snap();
      end
      check($sformatf("vec%0d len", k), 64'(cyc), 64'(vecs[k].len));
      check($sformatf("vec%0d last", k), 64'(last), 64'(vecs[k].last));
      check($sformatf("vec%0d npc", k), 64'(pc), 64'(vecs[k].npc));
    end

    // Reset asserted in the EXEC cycle of an ALU op: outputs drop at once and
    // the write-back never happens.
    do_reset();
    rom[0] = 16'h0250;
    @(negedge clk) start = 1'b1;
    repeat (3) begin
      @(negedge clk);
      start = 1'b0;
    end
    check("pre-reset exec", 64'(snap()),
          64'(act(8'h01, 8'h00, 3'd0, 3'd1, 3'd2, 3'd0, 6'b001110)));
    #2 rst_n = 1'b0;
    #1 check("async reset mid exec", 64'(snap()), 64'h0);
    repeat (2) begin
      @(negedge clk);
      check("write held low in reset", 64'(write), 64'h0);
    end
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("idle after mid-exec reset", 64'(snap()), 64'h0);
    end

    // LDI, ALU, HLT program, then start pulses while halted.
    do_reset();
    rom[0] = 16'h8205; rom[1] = 16'h0250; rom[2] = 16'hF000;
    @(negedge clk) start = 1'b1;
    run_prog(3, "ldi-alu-hlt");
    hpat = '0; hpat.pc = 8'h03; hpat.halted = 1'b1;
    for (int i = 0; i < 10; i++) begin
      start = (i % 2 == 0);
      @(negedge clk);
      check($sformatf("halt hold %0d", i), 64'(snap()), 64'(hpat));
    end
    start = 1'b0;

    // Branch to the last ROM word, then the pc wraps to 0.
    do_reset();
    for (int i = 0; i < 256; i++) rom[i] = 16'hD000;
    rom[0] = 16'hC0FF;
    @(negedge clk) start = 1'b1;
    run_prog(3, "wrap");

    // Random program (no HLT) checked cycle by cycle against the model.
    do_reset();
    for (int i = 0; i < 256; i++) begin
      rom[i] = 16'($urandom);
      if (rom[i][15:12] == 4'hF) rom[i][15:12] = 4'hD;
    end
    @(negedge clk) start = 1'b1;
    run_prog(300, "rand");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
